// File: rtl/invert_frame_decoder.sv
// invert_frame_decoder: finds slot phase of an invert-framed byte stream, verifies it, then decodes
module invert_frame_decoder #(
  parameter logic [7:0] TRAIN_WORD = 8'h3C,
  parameter int VERIFY_FRAMES = 2
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [7:0] enc_input,
  input  logic       resync,
  output logic [7:0] dec_output,
  output logic       dec_valid,
  output logic       frame_start,
  output logic       locked
);
  localparam logic [3:0] VF = VERIFY_FRAMES[3:0];
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
  state_t     state;
  logic [2:0] slot;
  logic [3:0] vcnt, vcnt_inc;
  logic [7:0] prev_word, expected, decoded;
  logic       prev_valid, detect, match;
  always_comb begin
    expected = (slot < 3'd5) ? TRAIN_WORD : ~TRAIN_WORD;
    decoded  = (slot < 3'd5) ? enc_input : ~enc_input;
    detect   = prev_valid && prev_word == ~TRAIN_WORD && enc_input == TRAIN_WORD;
    match    = enc_input == expected;
    vcnt_inc = (vcnt == 4'hF) ? vcnt : vcnt + 4'd1;
  end
  always_ff @(posedge clk) begin
    if (clear) begin
      state       <= HUNT;
      slot        <= 3'd0;
      vcnt        <= 4'd0;
      prev_valid  <= 1'b0;
      prev_word   <= 8'd0;
      dec_output  <= 8'd0;
      dec_valid   <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
    end else begin
      prev_word   <= enc_input;
      prev_valid  <= 1'b1;
      dec_output  <= 8'd0;
      dec_valid   <= 1'b0;
      frame_start <= 1'b0;
      slot        <= slot + 3'd1;
      if (resync) begin
        state  <= HUNT;
        slot   <= 3'd0;
        vcnt   <= 4'd0;
        locked <= 1'b0;
      end else begin
        case (state)
          HUNT: begin
            slot <= detect ? 3'd1 : 3'd0;
            vcnt <= 4'd0;
            if (detect) state <= VERIFY;
          end
          VERIFY: begin
            if (!match) begin
              state <= HUNT;
              slot  <= 3'd0;
              vcnt  <= 4'd0;
            end else if (slot == 3'd7) begin
              vcnt <= vcnt_inc;
              // the slot-0 word caught in HUNT counts toward the first frame
              if (vcnt_inc >= VF) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end
          end
          LOCKED: begin
            dec_output  <= decoded;
            dec_valid   <= 1'b1;
            frame_start <= slot == 3'd0;
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_invert_frame_decoder.sv
// tb_invert_frame_decoder: random and directed stimulus against a word-index model of the framed link
module tb_invert_frame_decoder;
  localparam logic [7:0] TW = 8'h3C;
  localparam int VF = 2;
  logic       clk = 0, clear = 1, resync = 0, clear_b = 1;
  logic [7:0] enc_input = 0, enc_b = 0;
  logic [7:0] dec_output, dec_b;
  logic       dec_valid, frame_start, locked, valid_b, fs_b, locked_b;
  int         checks = 0, errors = 0, ph = 0;
  bit         m_pv, m_cand, m_locked;
  logic [7:0] m_prev, e_out;
  bit         e_val, e_fs;
  int         m_base = 0, m_n = 0;

  invert_frame_decoder #(.TRAIN_WORD(TW), .VERIFY_FRAMES(VF)) dut (
    .clk(clk), .clear(clear), .enc_input(enc_input), .resync(resync),
    .dec_output(dec_output), .dec_valid(dec_valid), .frame_start(frame_start), .locked(locked));

  invert_frame_decoder #(.TRAIN_WORD(8'hFF), .VERIFY_FRAMES(1)) dut_b (
    .clk(clk), .clear(clear_b), .enc_input(enc_b), .resync(1'b0),
    .dec_output(dec_b), .dec_valid(valid_b), .frame_start(fs_b), .locked(locked_b));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the lock candidate is the word index of a detected slot 0; slots are index offsets mod 8
  always @(posedge clk) begin
    int k;
    e_out = 0; e_val = 0; e_fs = 0;
    if (clear) begin
      m_pv = 0; m_cand = 0; m_locked = 0; m_prev = 0;
    end else begin
      if (resync) begin
        m_cand = 0; m_locked = 0;
      end else if (m_locked) begin
        k = (m_n - m_base) % 8;
        e_out = (k < 5) ? enc_input : ~enc_input;
        e_val = 1; e_fs = (k == 0);
      end else if (m_cand) begin
        k = m_n - m_base;
        if (enc_input != (((k % 8) < 5) ? TW : ~TW)) m_cand = 0;
        else if (k == 8 * VF - 1) begin m_locked = 1; m_cand = 0; end
      end else if (m_pv && m_prev == ~TW && enc_input == TW) begin
        m_cand = 1; m_base = m_n;
      end
      m_prev = enc_input; m_pv = 1;
    end
    m_n++;
    #1;
    chk("model dec_output", dec_output, e_out);
    chk("model dec_valid", {7'd0, dec_valid}, {7'd0, e_val});
    chk("model frame_start", {7'd0, frame_start}, {7'd0, e_fs});
    chk("model locked", {7'd0, locked}, {7'd0, m_locked});
  end

  task automatic drive(input logic [7:0] w, input bit c, input bit r);
    enc_input = w; clear = c; resync = r;
    @(negedge clk);
  endtask

  task automatic step(input logic [7:0] b, input bit c, input bit r);
    drive((ph < 5) ? b : ~b, c, r);
    ph = (ph + 1) % 8;
  endtask

  task automatic enc(input logic [7:0] b);
    step(b, 0, 0);
  endtask

  task automatic drive_b(input logic [7:0] w, input bit c);
    enc_b = w; clear_b = c;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] wb [16];
    @(negedge clk);
    repeat (3) drive($urandom, 1, 0);
    chk("reset dec_output", dec_output, 8'd0);
    chk("reset dec_valid", {7'd0, dec_valid}, 8'd0);
    chk("reset frame_start", {7'd0, frame_start}, 8'd0);
    chk("reset locked", {7'd0, locked}, 8'd0);
    // phase offset 3: first slot-0 word is index 5, lock on index 20
    ph = 3;
    repeat (20) enc(TW);
    chk("lock not early", {7'd0, locked}, 8'd0);
    enc(TW);
    chk("lock at 15 after detect", {7'd0, locked}, 8'd1);
    for (int i = 0; i < 8; i++) begin
      enc(8'h11 + 8'(i));
      chk("payload byte", dec_output, 8'h11 + 8'(i));
      chk("payload valid", {7'd0, dec_valid}, 8'd1);
      chk("payload frame_start", {7'd0, frame_start}, (i == 0) ? 8'd1 : 8'd0);
    end
    step($urandom, 1, 0);
    chk("clear in lock locked", {7'd0, locked}, 8'd0);
    chk("clear in lock valid", {7'd0, dec_valid}, 8'd0);
    for (int i = 0; i < 40 && !(m_cand && ph == 6); i++) enc(TW);
    drive(8'h00, 0, 0);
    ph = (ph + 1) % 8;
    chk("corrupt slot6 locked", {7'd0, locked}, 8'd0);
    repeat (16) enc(TW);
    chk("relock not early", {7'd0, locked}, 8'd0);
    enc(TW);
    chk("relock", {7'd0, locked}, 8'd1);
    repeat (5) enc($urandom);
    step($urandom, 0, 1);
    chk("resync locked", {7'd0, locked}, 8'd0);
    chk("resync valid", {7'd0, dec_valid}, 8'd0);
    repeat (32) enc(TW);
    chk("reacquire locked", {7'd0, locked}, 8'd1);
    chk("reacquire decode", dec_output, TW);
    repeat (40) begin
      case ($urandom_range(0, 6))
        0, 1, 2: repeat ($urandom_range(8, 40)) enc(TW);
        3: repeat ($urandom_range(1, 20)) enc($urandom);
        4: step($urandom, 0, 1);
        5: step($urandom, 1, 0);
        default: enc(TW ^ (8'd1 << $urandom_range(0, 7)));
      endcase
    end
    // TRAIN_WORD=FF, VERIFY_FRAMES=1: a leading FF must not pair with the reset prev_word
    clear = 1;
    drive_b(8'h00, 1);
    wb = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00,
           8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 15; i++) begin
      drive_b(wb[i], 0);
      chk("ff no early lock", {7'd0, locked_b}, 8'd0);
      chk("ff no valid in hunt", {7'd0, valid_b}, 8'd0);
    end
    drive_b(wb[15], 0);
    chk("ff lock", {7'd0, locked_b}, 8'd1);
    drive_b(8'hA5, 0);
    chk("ff decode slot0", dec_b, 8'hA5);
    chk("ff frame_start", {7'd0, fs_b}, 8'd1);
    drive_b(8'h5A, 0);
    chk("ff decode slot1", dec_b, 8'h5A);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
